// File: rtl/dense_layer_seq.sv
// rtl/dense_layer_seq.sv - one fully connected layer with ReLU, one 8x8 MAC lane
// Neuron sequencing: MAC issue, DRAIN, WRITE, with the accumulate stage one cycle behind issue.
module dense_layer_seq #(
  parameter int IN_SIZE  = 16,
  parameter int OUT_SIZE = 8,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 0,
  localparam int IA_W    = $clog2(IN_SIZE),
  localparam int WA_W    = $clog2(IN_SIZE * OUT_SIZE),
  localparam int OA_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IA_W-1:0]   in_addr,
  input  logic signed [7:0] in_data,
  output logic [WA_W-1:0]   w_addr,
  input  logic signed [7:0] w_data,
  output logic [OA_W-1:0]   b_addr,
  input  logic signed [7:0] b_data,
  output logic              out_we,
  output logic [OA_W-1:0]   out_addr,
  output logic [7:0]        out_data
);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic [IA_W-1:0] J_LAST = IA_W'(IN_SIZE - 1);
  localparam logic [OA_W-1:0] O_LAST = OA_W'(OUT_SIZE - 1);

  state_t                   r_state;
  logic [OA_W-1:0]          r_o;
  logic [IA_W-1:0]          r_j;
  logic [WA_W-1:0]          r_w_addr;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_acc_valid;
  logic                     r_acc_first;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_out_we;
  logic [OA_W-1:0]          r_out_addr;
  logic [7:0]               r_out_data;

  logic signed [15:0]       w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [ACC_W-1:0]  w_shift;
  logic [7:0]               w_sat;

  assign w_prod     = in_data * w_data;
  assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
  assign w_bias_ext = {{(ACC_W-8){b_data[7]}}, b_data};

  // The first term loads bias+product so a stale accumulator never leaks into the next neuron.
  always_comb begin
    w_acc_next = r_acc;
    if (r_acc_valid) begin
      if (r_acc_first) w_acc_next = w_bias_ext + w_prod_ext;
      else             w_acc_next = r_acc + w_prod_ext;
    end
  end

  assign w_shift = w_acc_next >>> SHIFT;

  always_comb begin
    w_sat = {1'b0, w_shift[6:0]};
    if (w_shift[ACC_W-1])          w_sat = 8'd0;
    else if (|w_shift[ACC_W-2:7])  w_sat = 8'd127;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_o         <= '0;
      r_j         <= '0;
      r_w_addr    <= '0;
      r_acc       <= '0;
      r_acc_valid <= 1'b0;
      r_acc_first <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_we    <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_we    <= 1'b0;
      r_acc       <= w_acc_next;
      r_acc_valid <= (r_state == S_MAC);
      r_acc_first <= (r_state == S_MAC) && (r_j == '0);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_o      <= '0;
            r_j      <= '0;
            r_w_addr <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_j == J_LAST) begin
            r_state <= S_DRAIN;
          end else begin
            r_j      <= r_j + IA_W'(1);
            r_w_addr <= r_w_addr + WA_W'(1);
          end
        end
        // The last product lands this cycle, so the result is taken from the next-acc value.
        S_DRAIN: begin
          r_out_we   <= 1'b1;
          r_out_addr <= r_o;
          r_out_data <= w_sat;
          r_state    <= S_WRITE;
        end
        S_WRITE: begin
          if (r_o == O_LAST) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_o      <= r_o + OA_W'(1);
            r_j      <= '0;
            r_w_addr <= r_w_addr + WA_W'(1);
            r_state  <= S_MAC;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign in_addr  = r_j;
  assign w_addr   = r_w_addr;
  assign b_addr   = r_o;
  assign out_we   = r_out_we;
  assign out_addr = r_out_addr;
  assign out_data = r_out_data;

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb/tb_dense_layer_seq.sv - scoreboard bench for dense_layer_seq
// Two instances share the memories: SHIFT=0 and SHIFT=2, selected by sel.
`timescale 1ns/1ps
module tb_dense_layer_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  bit   sel = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  logic signed [7:0] in_mem [4];
  logic signed [7:0] w_mem  [8];
  logic signed [7:0] b_mem  [2];

  logic              busy0, done0, we0, busy1, done1, we1;
  logic [1:0]        in_a0, in_a1;
  logic [2:0]        w_a0, w_a1;
  logic [0:0]        b_a0, b_a1, oa0, oa1;
  logic signed [7:0] in_d0, w_d0, b_d0, in_d1, w_d1, b_d1;
  logic [7:0]        od0, od1;

  dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .ACC_W(24), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .in_addr(in_a0), .in_data(in_d0), .w_addr(w_a0), .w_data(w_d0),
    .b_addr(b_a0), .b_data(b_d0), .out_we(we0), .out_addr(oa0), .out_data(od0)
  );

  dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .ACC_W(24), .SHIFT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .in_addr(in_a1), .in_data(in_d1), .w_addr(w_a1), .w_data(w_d1),
    .b_addr(b_a1), .b_data(b_d1), .out_we(we1), .out_addr(oa1), .out_data(od1)
  );

  always @(posedge clk) begin
    in_d0 <= in_mem[in_a0];
    w_d0  <= w_mem[w_a0];
    b_d0  <= b_mem[b_a0];
    in_d1 <= in_mem[in_a1];
    w_d1  <= w_mem[w_a1];
    b_d1  <= b_mem[b_a1];
  end

  logic       m_busy, m_done, m_we;
  logic [0:0] m_addr;
  logic [7:0] m_data;

  always_comb begin
    m_busy = sel ? busy1 : busy0;
    m_done = sel ? done1 : done0;
    m_we   = sel ? we1   : we0;
    m_addr = sel ? oa1   : oa0;
    m_data = sel ? od1   : od0;
  end

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_mem(input int iv, input int wv, input int b0, input int b1);
    for (int j = 0; j < 4; j++) in_mem[j] = 8'(iv);
    for (int j = 0; j < 8; j++) w_mem[j] = 8'(wv);
    b_mem[0] = 8'(b0);
    b_mem[1] = 8'(b1);
  endtask

  function automatic int exp_out(input int o, input int sh);
    int acc;
    acc = int'(b_mem[o]);
    for (int j = 0; j < 4; j++) acc += int'(in_mem[j]) * int'(w_mem[o*4+j]);
    acc = acc >>> sh;
    if (acc < 0) return 0;
    if (acc > 127) return 127;
    return acc;
  endfunction

  // Cycle k below is counted from the start-sampling edge; k=1 is the first MAC cycle.
  task automatic run_layer(input int sh, input bit poke);
    exp_t e;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int o = 0; o < 2; o++) begin
      e.addr = o;
      e.data = exp_out(o, sh);
      e.cyc  = (o + 1) * 6;
      sb_q.push_back(e);
    end
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      chk("busy", 32'(m_busy), 32'(k <= 12));
      chk("done", 32'(m_done), 32'(k == 13));
      chk("out_we", 32'(m_we), 32'((k % 6 == 0) && (k <= 12)));
      if (m_we) begin
        if (sb_q.size() == 0) begin
          chk("sb_empty_on_write", 32'(sb_q.size()), 32'(1));
        end else begin
          e = sb_q.pop_front();
          chk("write_cycle", 32'(k), 32'(e.cyc));
          chk("out_addr", 32'(m_addr), 32'(e.addr));
          chk("out_data", 32'(m_data), 32'(e.data));
        end
      end
      if (poke && k == 3) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      if (k == 4) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
    end
    chk("sb_drained", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy0), 32'(0));
    chk({tag, "_done"}, 32'(done0), 32'(0));
    chk({tag, "_we"}, 32'(we0), 32'(0));
    chk({tag, "_in_addr"}, 32'(in_a0), 32'(0));
    chk({tag, "_w_addr"}, 32'(w_a0), 32'(0));
    chk({tag, "_b_addr"}, 32'(b_a0), 32'(0));
    chk({tag, "_out_addr"}, 32'(oa0), 32'(0));
    chk({tag, "_out_data"}, 32'(od0), 32'(0));
  endtask

  initial begin
    set_mem(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    sel = 1'b0;
    set_mem(1, 1, 0, 0);
    run_layer(0, 1'b0);
    set_mem(1, -1, 2, 10);
    run_layer(0, 1'b0);
    set_mem(127, 127, 127, 127);
    run_layer(0, 1'b0);
    set_mem(0, 0, -5, 5);
    run_layer(0, 1'b0);

    // Abort a run mid-neuron, then restart cleanly.
    set_mem(1, 1, 0, 0);
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    chk("rst_we_c5", 32'(we0), 32'(0));
    @(negedge clk);
    chk("rst_we_c6", 32'(we0), 32'(0));
    chk_zero("held_reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_we", 32'(we0), 32'(0));
    chk("post_rst_busy", 32'(busy0), 32'(0));
    set_mem(2, 3, -7, 1);
    run_layer(0, 1'b0);

    sel = 1'b1;
    set_mem(5, 5, 0, 0);
    run_layer(2, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_layer_seq.md
# dense_layer_seq

Time-multiplexed sequencer for one fully connected layer with ReLU. It drives a single signed 8x8 multiply-accumulate lane over synchronous-read weight, bias and input memories, one output neuron at a time. It writes each saturated result to an output buffer. It replaces the fully combinational dense layer wherever area matters more than latency, and a network controller chains instances by connecting one `done` to the next `start`.

## Interface
- `IN_SIZE`, 16: number of inputs per neuron, ≥2.
- `OUT_SIZE`, 8: number of neurons, ≥1.
- `ACC_W`, 24: accumulator width; must be ≥ 17 + $clog2(IN_SIZE).
- `SHIFT`, 0: arithmetic right shift applied to the accumulator before ReLU and saturation.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: 1-cycle request to run the layer. Sampled only in IDLE.
- `busy` out 1: high from the first MAC cycle through the last WRITE cycle.
- `done` out 1: 1-cycle pulse after the final write.
- `in_addr` out $clog2(IN_SIZE): input-vector read address.
- `in_data` in 8: signed input; valid 1 cycle after `in_addr`.
- `w_addr` out $clog2(IN_SIZE*OUT_SIZE): weight address, row-major (o*IN_SIZE+j).
- `w_data` in 8: signed weight; valid 1 cycle after `w_addr`.
- `b_addr` out $clog2(OUT_SIZE): bias address.
- `b_data` in 8: signed bias; valid 1 cycle after `b_addr`.
- `out_we` out 1: output-buffer write strobe.
- `out_addr` out $clog2(OUT_SIZE): neuron index being written.
- `out_data` out 8: signed result, always in the range 0..127.

## Operation
- Counters:
  - `o` is the neuron index, 0..OUT_SIZE-1.
  - `j` is the input index, 0..IN_SIZE-1.
  - `acc` is a signed ACC_W-bit accumulator.
  - The accumulate stage uses a 1-cycle-delayed copy of "first" and "valid".
- FSM states: IDLE, MAC, DRAIN, WRITE, DONE.
- IDLE: on `start`=1, set o=0 and j=0, then go to MAC. Otherwise stay in IDLE.
- MAC, issue stage:
  - Drive in_addr=j and w_addr=o*IN_SIZE+j.
  - When j=0, also drive b_addr=o.
  - Increment j. When j=IN_SIZE-1, go to DRAIN.
- Accumulate stage, running one cycle behind issue:
  - For the first term, acc <= sext(b_data) + in_data*w_data.
  - Otherwise, acc <= acc + in_data*w_data.
  - Products are full 16-bit signed values, sign-extended to ACC_W. No truncation happens during accumulation.
- DRAIN: accumulate the last product. Issue nothing. Go to WRITE.
- WRITE:
  - Assert out_we=1 with out_addr=o.
  - Compute out_data from s = acc >>> SHIFT: 0 if s<0; 127 if s>127; otherwise s[7:0].
  - If o=OUT_SIZE-1, go to DONE. Otherwise set o=o+1 and j=0, and go to MAC.
- DONE: assert done=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Address outputs hold their last value when not issuing. Memories must tolerate this.
- `rst_n` low at any time:
  - Immediately enter IDLE and clear o, j and acc.
  - Drive busy=0, done=0, out_we=0, all addresses 0 and out_data 0.
  - A partial layer is abandoned. Outputs already written stay in the buffer, and no further writes occur.

## Timing
- Reset values: every output is 0.
- Each neuron takes exactly IN_SIZE+2 cycles: IN_SIZE MAC cycles, 1 DRAIN cycle and 1 WRITE cycle.
- Let `start` be sampled at edge 0:
  - The first MAC cycle is cycle 1.
  - The write for neuron o occurs in cycle (o+1)*(IN_SIZE+2).
  - `done` is high in cycle OUT_SIZE*(IN_SIZE+2)+1.
- `busy` is low in IDLE and DONE. A new `start` is accepted in the cycle after `done`.
- Memory contract: read data for address A, presented in cycle t, must be valid throughout cycle t+1.
- `out_we`, `out_addr` and `out_data` are registered and valid together for one cycle. The buffer captures them at the end of that cycle.
- There is no stall input. The layer runs at full rate once started.

## Test plan
- IN_SIZE=4, OUT_SIZE=2, all inputs=1, all weights=1, biases=0, start at edge 0 -> writes (addr0, 4) in cycle 6 and (addr1, 4) in cycle 12; done in cycle 13; busy high in cycles 1–12.
- Same sizes, inputs=1, weights=-1, bias0=2, bias1=10 -> out0=0 (ReLU of -2), out1=6.
- Inputs=127, weights=127, bias=127 -> accumulator 64643; out=127 (saturated); no sign wrap.
- Inputs all 0, biases -5 and 5 -> outputs 0 and 5. This checks bias sign-extension and that the first-term load replaces any stale acc.
- SHIFT=2, inputs=5, weights=5, bias=0 (acc=100) -> out=25. Also pulse `start` in cycle 3 -> ignored; exactly 2 writes and 1 done.
- Assert `rst_n` low in cycle 4, release in cycle 6, start at edge 8 -> no write in cycle 6; all outputs 0 during reset; the fresh run completes normally with done in cycle 21.
